// File: rtl/audio_pkg.sv
// Audio constants shared by the loopback chain (reverb, I2S transmitter and receiver).
package audio_pkg;

  localparam int AUDIO_SAMPLE_W  = 16;
  localparam int I2S_SLOT_W      = 32;
  localparam int I2S_CLK_DIV_48K = 2;

  typedef logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock generator: divides clk into BCLK and flags the edge on which BCLK will toggle.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV_48K
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic bclk_rise,
  output logic bclk_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             bclk_r;
  logic             tc_s;

  assign tc_s = (div_cnt_r == DIV_LAST);

  // Half-period divider; BCLK toggles at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bclk_r    <= 1'b0;
    end else if (tc_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bclk_r    <= ~bclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Strobes are true on the clk edge that moves BCLK.
  assign bclk_rise = tc_s & ~bclk_r;
  assign bclk_fall = tc_s & bclk_r;
  assign bclk      = bclk_r;

endmodule

// File: rtl/i2s_tx_stereo_m.sv
// I2S (Philips) stereo transmitter: one-pair holding register with valid/ready upstream,
// serialised MSB-first one BCLK after each LRCK edge, zero-padded to SLOT_W bits per channel.
module i2s_tx_stereo_m
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int CLK_DIV  = I2S_CLK_DIV_48K
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                bclk,
  output logic                lrck,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  localparam int PAIR_W     = 2 * SAMPLE_W;
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN  = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(SAMPLE_W);

  logic              bclk_fall_s;
  logic              bclk_rise_unused_s;
  logic              frame_ev_s;
  logic              accept_s;
  logic              lrck_nxt_s;
  logic              data_pos_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [CNT_W-1:0]  bit_nxt_s;
  logic [CNT_W-1:0]  pos_s;
  logic [PAIR_W-1:0] hold_r;
  logic [PAIR_W-1:0] shift_r;
  logic              ready_r;
  logic              lrck_r;
  logic              sdata_r;
  logic              frame_start_r;
  logic              underrun_r;

  i2s_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .bclk     (bclk),
    .bclk_rise(bclk_rise_unused_s),
    .bclk_fall(bclk_fall_s)
  );

  assign frame_ev_s = bclk_fall_s & (bit_cnt_r == CNT_LAST);
  assign accept_s   = s_valid & ready_r;
  assign bit_nxt_s  = (bit_cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : bit_cnt_r + CNT_W'(1);

  // Channel and in-slot position of the bit that the coming fall event will present.
  always_comb begin
    lrck_nxt_s = 1'b0;
    pos_s      = bit_nxt_s;
    if (bit_nxt_s >= SLOT_LEN) begin
      lrck_nxt_s = 1'b1;
      pos_s      = bit_nxt_s - SLOT_LEN;
    end else begin
      lrck_nxt_s = 1'b0;
      pos_s      = bit_nxt_s;
    end
  end

  // Position 0 is the trailing pad bit of the previous slot, so data occupies 1..SAMPLE_W.
  assign data_pos_s = (pos_s != {CNT_W{1'b0}}) && (pos_s <= DATA_LAST);

  // Serialiser: bit counter, word select and data all move together with BCLK falling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= CNT_LAST;
      lrck_r    <= 1'b1;
      sdata_r   <= 1'b0;
      shift_r   <= {PAIR_W{1'b0}};
    end else if (bclk_fall_s) begin
      bit_cnt_r <= bit_nxt_s;
      lrck_r    <= lrck_nxt_s;
      if (frame_ev_s) begin
        shift_r <= ready_r ? {PAIR_W{1'b0}} : hold_r;
        sdata_r <= 1'b0;
      end else if (data_pos_s) begin
        sdata_r <= shift_r[PAIR_W-1];
        shift_r <= {shift_r[PAIR_W-2:0], 1'b0};
      end else begin
        sdata_r <= 1'b0;
      end
    end
  end

  // Holding register; a frame event drains it before any new accept is possible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
      hold_r  <= {PAIR_W{1'b0}};
    end else if (frame_ev_s && !ready_r) begin
      ready_r <= 1'b1;
    end else if (accept_s) begin
      ready_r <= 1'b0;
      hold_r  <= {s_left, s_right};
    end
  end

  // Frame and underrun pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      frame_start_r <= frame_ev_s;
      underrun_r    <= frame_ev_s & ready_r;
    end
  end

  assign s_ready     = ready_r;
  assign lrck        = lrck_r;
  assign sdata       = sdata_r;
  assign frame_start = frame_start_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_i2s_tx_stereo_m.sv
// Scoreboard bench for i2s_tx_stereo_m: accepted pairs are queued, each frame_start turns the
// next pair (or silence) into the 64 expected {lrck,sdata} values seen on BCLK rising.
module tb_i2s_tx_stereo_m;

  localparam int FRAME_CLKS = 2 * 2 * 2 * 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_left;
  logic [15:0] s_right;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        frame_start;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  i2s_tx_stereo_m #(
    .SAMPLE_W(16),
    .SLOT_W  (32),
    .CLK_DIV (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .bclk       (bclk),
    .lrck       (lrck),
    .sdata      (sdata),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Scoreboard state
  logic [1:0]  bitq[$];
  logic [31:0] pairq[$];
  int          cyc;
  int          last_frame;
  bit          seen_rise;
  bit          seen_frame;
  bit          prev_bclk;
  bit          pend;
  logic [31:0] pend_pair;

  // Reference: a frame is left slot then right slot; slot position p carries sample bit 16-p
  // for p in 1..16, every other position is zero.
  task automatic push_frame(input logic [31:0] pair);
    logic [15:0] smp;
    logic        b;
    for (int ch = 0; ch < 2; ch++) begin
      smp = (ch == 0) ? pair[31:16] : pair[15:0];
      for (int p = 0; p < 32; p++) begin
        b = (p >= 1 && p <= 16) ? smp[16-p] : 1'b0;
        bitq.push_back({(ch == 1), b});
      end
    end
  endtask

  // Monitor: runs between edges; cyc equals the number of posedges since reset release.
  always @(negedge clk) begin
    logic [1:0]  want;
    logic [31:0] pr;
    if (!rst_n) begin
      bitq.delete();
      pairq.delete();
      cyc        = 0;
      last_frame = 0;
      seen_rise  = 1'b0;
      seen_frame = 1'b0;
      prev_bclk  = 1'b0;
      pend       = 1'b0;
    end else begin
      cyc++;
      if (bclk && !prev_bclk) begin
        if (!seen_rise) begin
          chk("first_bclk_rise_cycle", cyc, 2);
          seen_rise = 1'b1;
        end
        if (bitq.size() > 0) begin
          want = bitq.pop_front();
          chk("wire_lrck_sdata", int'({lrck, sdata}), int'(want));
        end else begin
          chk("idle_lrck_sdata", int'({lrck, sdata}), 2);
        end
      end
      prev_bclk = bclk;
      if (frame_start) begin
        if (seen_frame) chk("frame_period", cyc - last_frame, FRAME_CLKS);
        else chk("first_frame_cycle", cyc, 4);
        chk("frame_bits_consumed", bitq.size(), 0);
        chk("underrun_flag", int'(underrun), int'(pairq.size() == 0));
        seen_frame = 1'b1;
        last_frame = cyc;
        pr = (pairq.size() > 0) ? pairq.pop_front() : 32'h0;
        push_frame(pr);
      end else if (underrun) begin
        chk("underrun_without_frame", int'(underrun), 0);
      end
      if (pend) pairq.push_back(pend_pair);
      pend      = s_valid && s_ready;
      pend_pair = {s_left, s_right};
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_bclk"}, int'(bclk), 0);
    chk({tag, "_lrck"}, int'(lrck), 1);
    chk({tag, "_sdata"}, int'(sdata), 0);
    chk({tag, "_s_ready"}, int'(s_ready), 1);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_underrun"}, int'(underrun), 0);
  endtask

  // Present a pair and keep it until accepted; returns the posedge index of acceptance.
  task automatic send(input logic [15:0] l, input logic [15:0] r, output int acc);
    int n;
    bit ok;
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    n   = 0;
    ok  = 1'b0;
    acc = -1;
    while (!ok && n < 2000) begin
      if (s_ready) begin
        @(posedge clk);
        #1;
        acc = cyc + 1;
        ok  = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    s_valid = 1'b0;
    chk("send_accepted", int'(ok), 1);
  endtask

  task automatic wait_frame();
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 600) begin
      @(posedge clk);
      #1;
      n++;
      if (frame_start) got = 1'b1;
    end
    chk("frame_seen", int'(got), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_left  = 16'h0000;
    s_right = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pair accepted before the first frame
    send(16'hA5C3, 16'h5A3C, acc);

    // s_valid held continuously: each later pair lands the cycle after a frame_start
    for (int i = 0; i < 6; i++) begin
      send(16'($urandom), 16'($urandom), acc);
      if (i > 0) chk("held_accept_after_frame", acc - last_frame, 1);
    end

    // Feed stops: silent underrun frames follow
    repeat (3 * FRAME_CLKS) @(posedge clk);
    #1;

    // Extreme values, then randomly spaced pairs
    send(16'h8000, 16'h7FFF, acc);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 300)) @(posedge clk);
      #1;
      send(16'($urandom), 16'($urandom), acc);
    end
    repeat (2 * FRAME_CLKS + 8) @(posedge clk);
    #1;

    // Reset in the middle of a left slot with a pair held: the pair must be lost
    wait_frame();
    send(16'($urandom), 16'($urandom), acc);
    repeat (39) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    reset_checks("mid");
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2 * FRAME_CLKS) @(posedge clk);
    #1;

    send(16'($urandom), 16'($urandom), acc);
    repeat (2 * FRAME_CLKS + 8) @(posedge clk);
    #1;
    chk("pairs_drained", pairq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
